// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel plus the
// decoder-facing instruction head and its branch-resolution feedback.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] immext;

    // The fetch unit itself: issues memory requests and presents the head instruction.
    modport master (
        output imem_req, imem_addr, instr, instr_pc, pcplus4, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, branch, zero, immext
    );

    // The environment: instruction memory and the downstream decode/execute stage.
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, pcplus4, instr_valid,
        output imem_ack, imem_rdata, instr_ready, branch, zero, immext
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps at most one memory request outstanding, queues
// returned words in a small in-order buffer, and redirects on a taken branch
// at the buffer head, discarding any in-flight response that belongs to the
// abandoned path.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] { IDLE, WAIT, DROP } state_e;

    state_e        state_q;
    logic          req_q;
    logic [31:0]   addr_q;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   bufPc_q    [DEPTH];
    logic [31:0]   bufInstr_q [DEPTH];

    logic          headValid;
    logic          transfer;
    logic          redirect;
    logic          push;
    logic [31:0]   target;
    logic [IW-1:0] pushIdx;

    assign headValid = (count_q != '0);
    assign transfer  = headValid && bus.instr_ready;
    assign redirect  = transfer && bus.branch && bus.zero;
    assign target    = (bufPc_q[0] + bus.immext) & 32'hFFFF_FFFC;
    assign push      = (state_q == WAIT) && bus.imem_ack && !redirect;
    assign pushIdx   = IW'(count_q - CW'(transfer));

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = headValid;
    assign bus.instr       = headValid ? bufInstr_q[0]        : 32'd0;
    assign bus.instr_pc    = headValid ? bufPc_q[0]           : 32'd0;
    assign bus.pcplus4     = headValid ? bufPc_q[0] + 32'd4   : 32'd0;

    // Next fetch PC: a taken branch wins; otherwise advance only when a live request completes.
    always_comb begin
        fpc_d = fpc_q;
        if (redirect) begin
            fpc_d = target;
        end else if ((state_q == WAIT) && bus.imem_ack) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    // Buffer occupancy: a redirect empties it, otherwise push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(transfer);
        end
    end

    // Request state machine; the request/address outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            fpc_q   <= RESET_PC;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (!redirect && (count_q != CW'(DEPTH))) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= fpc_q;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else if (redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Shift-register buffer with the head at entry 0; the pushed word lands after the pop.
    always_ff @(posedge clk) begin
        if (!rst && !redirect) begin
            if (transfer) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    bufPc_q[i]    <= bufPc_q[i + 1];
                    bufInstr_q[i] <= bufInstr_q[i + 1];
                end
            end
            if (push) begin
                bufPc_q[pushIdx]    <= fpc_q;
                bufInstr_q[pushIdx] <= bus.imem_rdata;
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of instruction buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; held stable while imem_req=1 and imem_ack=0.
REQ-007 imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  buffer head instruction; instr[6:0] drives the main decoder op input.
REQ-010 instr_pc  output  32  PC of the buffer head.
REQ-011 pcplus4  output  32  instr_pc + 4.
REQ-012 instr_valid  output  1  buffer head is valid.
REQ-013 instr_ready  input  1  downstream consumes the head this cycle.
REQ-014 branch  input  1  branch control from the decoder for the head instruction.
REQ-015 zero  input  1  ALU zero flag for the head instruction.
REQ-016 immext  input  32  sign-extended branch offset for the head instruction.

Function
REQ-017 The state machine SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding, response kept), and DROP (request outstanding, response discarded).
REQ-018 IDLE->WAIT SHALL occur when free = DEPTH - count > 0 and no redirect occurs; imem_req SHALL be 1 in WAIT and DROP only.
REQ-019 In WAIT, when imem_ack=1, the block SHALL push {fpc, imem_rdata} into the buffer, set fpc <= fpc+4, and go to IDLE.
REQ-020 A transfer SHALL occur when instr_valid=1 and instr_ready=1; it pops the head one cycle later.
REQ-021 A redirect SHALL occur when a transfer occurs with branch=1 and zero=1.
REQ-022 On redirect, the block SHALL flush all buffer entries, including any same-cycle push, and set fpc <= {instr_pc + immext}[31:2], 2'b00, with the 32-bit sum wrapping modulo 2^32.
REQ-023 On redirect, WAIT without ack SHALL go to DROP.
REQ-024 On redirect, WAIT with ack SHALL discard the data and go to IDLE.
REQ-025 In DROP, imem_ack=1 SHALL discard the data, leave fpc unchanged, and go to IDLE.
REQ-026 imem_addr SHALL be fpc in WAIT; in DROP it SHALL hold the address of the dropped request until ack.
REQ-027 A simultaneous push and pop without redirect SHALL leave count unchanged and preserve order.
REQ-028 A new request SHALL NOT be issued when count = DEPTH; the request issued while at count = DEPTH-1 reserves the last entry.
REQ-029 Pipeline latency SHALL be as follows: request issued cycle N, ack at cycle M >= N, instr_valid=1 from cycle M+1.
REQ-030 instr, instr_pc, and pcplus4 SHALL be 0 when instr_valid=0.
REQ-031 fpc SHALL wrap from 32'hFFFF_FFFC to 0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set state=IDLE, fpc=RESET_PC, count=0, instr_valid=0, and imem_req=0, overriding any ack, redirect, or transfer in that cycle.
REQ-033 Reset during WAIT or DROP SHALL abandon the outstanding request; a late ack after reset (state IDLE) SHALL be ignored.
REQ-034 The first request SHALL be issued in the cycle after rst deasserts.

Verification
REQ-035 Reset release with imem_ack tied to 1 and instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_pc follows one cycle behind the acks; no gaps.
REQ-036 instr_ready=0 with ack always 1 -> count reaches DEPTH and imem_req drops to 0; raising ready releases instructions in order 0,4 (DEPTH=2).
REQ-037 Head at PC 0x10 with branch=1, zero=1, immext=-8 while WAIT for 0x18 has no ack -> buffer flushed, DROP entered; the ack for 0x18 is discarded; the next request is at 0x08.
REQ-038 Redirect in the same cycle as an ack -> data discarded; the next imem_addr is the target; instr_valid stays 0 until the target returns.
REQ-039 branch=1, zero=0 at head -> no flush; sequential PCs continue.
REQ-040 rst pulsed while in DROP, then a stale ack -> ack ignored; the first request is at RESET_PC; instr_valid=0 until its ack.
